// File: rtl/load_align_unit.sv
// load_align_unit
//   Multicycle data-memory load path. Accepts one load request, issues a
//   single word read, waits for the memory latency, then returns the
//   selected byte/halfword/word right-aligned and sign- or zero-extended.
//   Byte lanes are little-endian: byte k of a word is bits [8k+7:8k].
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   request strobe, sampled only while idle
//   funct[2:0] in   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (others illegal)
//   addr[31:0] in   byte address of the load
//   busy       out  high whenever a request is in progress
//   done       out  one-cycle completion pulse
//   err        out  qualified by done: misaligned address or illegal funct
//   data_out   out  extended load result, held until the next good load
//   mem_addr   out  word address of the read, qualified by mem_rd
//   mem_rd     out  one-cycle memory read strobe
//   mem_rdata  in   memory read data, valid MEM_LATENCY cycles after mem_rd
module load_align_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  // WAIT exits when the counter reads 1, so loading LATENCY-1 in REQ puts
  // CAPTURE exactly MEM_LATENCY cycles after the REQ cycle.
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  funct_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [2:0]  cnt_q;
  logic [31:0] data_q;
  logic [31:0] mem_addr_q;
  logic        bad_req;

  // Illegal opcode or an address not aligned to the access size.
  function automatic logic req_bad(input logic [2:0] f, input logic [1:0] o);
    logic bad;
    case (f)
      F_LB, F_LBU: bad = 1'b0;
      F_LH, F_LHU: bad = o[0];
      F_LW:        bad = (o != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed lane(s) and extend to 32 bits.
  function automatic logic [31:0] align_extend(input logic [2:0]  f,
                                               input logic [1:0]  o,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (o)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = o[1] ? word[31:16] : word[15:0];
    case (f)
      F_LB:    r = {{24{b[7]}}, b};
      F_LBU:   r = {24'd0, b};
      F_LH:    r = {{16{h[15]}}, h};
      F_LHU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign bad_req = req_bad(funct, addr[1:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = bad_req ? S_DONE : S_REQ;
      S_REQ:     state_nxt = (MEM_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (cnt_q == 3'd1) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      funct_q    <= 3'd0;
      off_q      <= 2'd0;
      err_q      <= 1'b0;
      cnt_q      <= 3'd0;
      data_q     <= 32'd0;
      mem_addr_q <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            funct_q <= funct;
            off_q   <= addr[1:0];
            err_q   <= bad_req;
            // Only a request that will reach REQ moves the memory address.
            if (!bad_req) mem_addr_q <= {addr[31:2], 2'b00};
          end
        end
        S_REQ:     cnt_q <= CNT_INIT;
        S_WAIT:    cnt_q <= cnt_q - 3'd1;
        S_CAPTURE: data_q <= align_extend(funct_q, off_q, mem_rdata);
        default: ;
      endcase
    end
  end

  // Decoded straight from the state register so reset clears them at once.
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_DONE) && err_q;
  assign mem_rd   = (state == S_REQ);
  assign data_out = data_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Read-side counterpart to the store-merge path. It runs a multicycle data-memory read and returns the selected byte, halfword or word, right-aligned and sign- or zero-extended, for register writeback.
- Sits between the datapath control FSM and the word-wide data memory.
- Lane mapping is little-endian: byte k of a word is bits [8k+7:8k]. This is the same mapping the store-merge path uses.

Parameters:
- MEM_LATENCY, 1, cycles from the mem_rd cycle to the cycle in which mem_rdata is valid; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- funct  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- addr  in  32  byte address of the load.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 means misaligned address or illegal funct.
- data_out  out  32  extended load result; registered, held until the next successful done.
- mem_addr  out  32  word address {addr_q[31:2], 2'b00}.
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy, done, err, mem_rd = 0; mem_addr = 0; data_out = 0; latency counter = 0.
  - mem_rd deasserts immediately on reset, mid-operation included.
- States: IDLE, REQ, WAIT, CAPTURE, DONE.
- IDLE:
  - On start=1, latch funct_q and addr_q.
  - If funct is illegal, or the access is misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=00): set err_q=1 and go to DONE. No memory request is made.
  - Otherwise set err_q=0 and go to REQ.
- REQ:
  - mem_rd=1 for exactly this cycle; mem_addr is valid.
  - If MEM_LATENCY=1, go to CAPTURE; otherwise load the counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter; go to CAPTURE when it reaches 1.
- CAPTURE:
  - mem_rdata is valid this cycle, i.e. REQ cycle + MEM_LATENCY.
  - Register the extended result into data_out at the end of the cycle; go to DONE.
- DONE:
  - done=1 and err=err_q for this one cycle; next state is IDLE.
  - data_out holds its new value from this cycle onward.
- mem_addr holds its last value outside REQ; only mem_rd qualifies it.
- Latency, start cycle to done cycle:
  - Successful load: MEM_LATENCY+2 cycles. With MEM_LATENCY=1, start in cycle 0 gives REQ in cycle 1, CAPTURE in cycle 2, done in cycle 3.
  - Error: done in the cycle after start.
- Extraction (o = addr_q[1:0]):
  - LB: sign-extend byte o to 32 bits.
  - LBU: zero-extend byte o.
  - LH: sign-extend bits [16*o[1]+15 : 16*o[1]].
  - LHU: zero-extend the same halfword.
  - LW: full word, unchanged.
- Error completion: data_out is NOT updated and keeps the prior value.
- start while busy (DONE included) is ignored. The next request is accepted no earlier than the cycle after DONE, so back-to-back throughput is one load per MEM_LATENCY+3 cycles.
- Inputs funct and addr are don't-care after the start cycle; the block uses the latched copies only.
- done and err are never high outside DONE; mem_rd is never high outside REQ.

Test Plan:
All memory cases use the word 0x8899AABB at address 0x100 and MEM_LATENCY=1 unless stated.
- Reset: after reset release, all outputs are 0 and busy=0. Assert reset_n=0 in WAIT with MEM_LATENCY=3 -> mem_rd=0, busy=0, data_out=0 immediately, with no clock edge needed.
- LW addr 0x100 at cycle 0:
  - mem_rd=1 and mem_addr=0x100 in cycle 1 only.
  - done=1, err=0, data_out=0x8899AABB in cycle 3.
  - Repeat with MEM_LATENCY=4 -> done in cycle 6.
- Byte loads:
  - LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA.
  - LB 0x103 -> 0xFFFFFF88; LBU 0x100 -> 0x000000BB.
  - For each, mem_addr=0x100.
- Halfword loads:
  - LH 0x102 -> 0xFFFF8899; LHU 0x102 -> 0x00008899.
  - LH 0x100 -> 0xFFFFAABB; LHU 0x100 -> 0x0000AABB.
- Errors (LW 0x102, LH 0x101, funct=011 at 0x100), each issued after a prior LW that left data_out=0x8899AABB:
  - done=1 and err=1 in cycle 1.
  - mem_rd never asserted.
  - data_out stays 0x8899AABB.
- Busy handling:
  - Pulse start (LB 0x103) in cycles 1, 2 and 3 of an in-flight LW at 0x100 -> ignored; exactly one done, data_out=0x8899AABB.
  - A start in cycle 4 is accepted -> done in cycle 7 with data_out=0xFFFFFF88.
